// File: rtl/multi_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel state
// encoding, reset defaults and the configuration-select width helper.
package multi_tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ONESHOT = 2'd2
    } chan_state_e;

    localparam int DEFAULT_PERIOD = 1_000_000;
    localparam int DEFAULT_PW     = 10;

    // A single channel still needs a one-bit select port.
    function automatic int sel_w(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: period counter, IDLE/RUN/ONESHOT state machine,
// shadow configuration registers and the pulse stretcher.
module tick_chan #(
    parameter int CNT_W          = 24,
    parameter int PW_W           = 4,
    parameter int DEFAULT_PERIOD = multi_tick_gen_pkg::DEFAULT_PERIOD,
    parameter int DEFAULT_PW     = multi_tick_gen_pkg::DEFAULT_PW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PW_W-1:0]  cfg_pw,
    output logic             tick,
    output logic             pulse,
    output logic             busy
);
    import multi_tick_gen_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW_W-1:0]  PW_ZERO  = {PW_W{1'b0}};
    localparam logic [PW_W-1:0]  PW_ONE   = {{(PW_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [PW_W-1:0]  PW_RST   = PW_W'(DEFAULT_PW);

    chan_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] per_act_r;
    logic [CNT_W-1:0] per_shd_r;
    logic [PW_W-1:0]  pw_act_r;
    logic [PW_W-1:0]  pw_shd_r;
    logic [PW_W-1:0]  pw_cnt_r;
    logic             tick_r;
    logic             pulse_r;
    logic             busy_r;

    logic [CNT_W-1:0] per_nxt_s;
    logic [CNT_W-1:0] per_use_s;
    logic [PW_W-1:0]  pw_nxt_s;
    logic [PW_W-1:0]  pw_use_s;
    logic             go_s;
    logic             restart_s;
    logic             one_mode_s;
    logic [CNT_W-1:0] cnt_eff_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             wrap_s;
    chan_state_e      st_nxt_s;
    logic             pulse_nxt_s;
    logic [PW_W-1:0]  pw_cnt_nxt_s;

    // Shadow bypass: a write landing on a load cycle is taken directly.
    always_comb begin
        per_nxt_s = cfg_we ? cfg_period : per_shd_r;
        pw_nxt_s  = cfg_we ? cfg_pw : pw_shd_r;
        if (state_r == ST_IDLE) begin
            per_use_s = per_nxt_s;
            pw_use_s  = pw_nxt_s;
        end else begin
            per_use_s = per_act_r;
            pw_use_s  = pw_act_r;
        end
    end

    // The cycle that leaves IDLE (or re-arms a one-shot) counts as count 0,
    // so the first tick lands exactly P cycles after en/start.
    always_comb begin
        go_s       = 1'b0;
        restart_s  = 1'b1;
        one_mode_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                go_s       = en & (~oneshot | start);
                restart_s  = 1'b1;
                one_mode_s = oneshot;
            end
            ST_RUN: begin
                go_s       = en;
                restart_s  = 1'b0;
                one_mode_s = 1'b0;
            end
            ST_ONESHOT: begin
                go_s       = en;
                restart_s  = start;
                one_mode_s = 1'b1;
            end
            default: begin
                go_s       = 1'b0;
                restart_s  = 1'b1;
                one_mode_s = 1'b0;
            end
        endcase
    end

    // Counter step, wrap detection and next state.
    always_comb begin
        cnt_eff_s = restart_s ? CNT_ZERO : cnt_r;
        if (go_s && (per_use_s != CNT_ZERO)) begin
            wrap_s = (cnt_eff_s >= (per_use_s - CNT_ONE));
        end else begin
            wrap_s = 1'b0;
        end
        if (!go_s || wrap_s || (per_use_s == CNT_ZERO)) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_eff_s + CNT_ONE;
        end
        if (!go_s) begin
            st_nxt_s = ST_IDLE;
        end else if (one_mode_s && wrap_s) begin
            st_nxt_s = ST_IDLE;
        end else if (one_mode_s) begin
            st_nxt_s = ST_ONESHOT;
        end else begin
            st_nxt_s = ST_RUN;
        end
    end

    // Pulse stretcher: each tick reloads the width counter.
    always_comb begin
        if (wrap_s) begin
            if (pw_use_s != PW_ZERO) begin
                pulse_nxt_s  = 1'b1;
                pw_cnt_nxt_s = pw_use_s - PW_ONE;
            end else begin
                pulse_nxt_s  = 1'b0;
                pw_cnt_nxt_s = PW_ZERO;
            end
        end else if (pw_cnt_r != PW_ZERO) begin
            pulse_nxt_s  = 1'b1;
            pw_cnt_nxt_s = pw_cnt_r - PW_ONE;
        end else begin
            pulse_nxt_s  = 1'b0;
            pw_cnt_nxt_s = PW_ZERO;
        end
    end

    // Channel state, configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            per_act_r <= PER_RST;
            per_shd_r <= PER_RST;
            pw_act_r  <= PW_RST;
            pw_shd_r  <= PW_RST;
            pw_cnt_r  <= PW_ZERO;
            tick_r    <= 1'b0;
            pulse_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            per_shd_r <= per_nxt_s;
            pw_shd_r  <= pw_nxt_s;
            if (!en || (state_r == ST_IDLE) || wrap_s) begin
                per_act_r <= per_nxt_s;
                pw_act_r  <= pw_nxt_s;
            end else begin
                per_act_r <= per_act_r;
                pw_act_r  <= pw_act_r;
            end
            if (!en) begin
                state_r  <= ST_IDLE;
                cnt_r    <= CNT_ZERO;
                pw_cnt_r <= PW_ZERO;
                tick_r   <= 1'b0;
                pulse_r  <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                state_r  <= st_nxt_s;
                cnt_r    <= cnt_nxt_s;
                pw_cnt_r <= pw_cnt_nxt_s;
                tick_r   <= wrap_s;
                pulse_r  <= pulse_nxt_s;
                busy_r   <= go_s;
            end
        end
    end

    assign tick  = tick_r;
    assign pulse = pulse_r;
    assign busy  = busy_r;

endmodule

// File: rtl/multi_tick_gen.sv
// NUM_CH independent tick channels sharing one configuration write port;
// the top only decodes cfg_sel and replicates tick_chan.
module multi_tick_gen #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 24,
    parameter int PW_W           = 4,
    parameter int DEFAULT_PERIOD = multi_tick_gen_pkg::DEFAULT_PERIOD,
    parameter int DEFAULT_PW     = multi_tick_gen_pkg::DEFAULT_PW
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CH-1:0]                             en,
    input  logic [NUM_CH-1:0]                             oneshot,
    input  logic [NUM_CH-1:0]                             start,
    input  logic                                          cfg_we,
    input  logic [multi_tick_gen_pkg::sel_w(NUM_CH)-1:0]  cfg_sel,
    input  logic [CNT_W-1:0]                              cfg_period,
    input  logic [PW_W-1:0]                               cfg_pw,
    output logic [NUM_CH-1:0]                             tick,
    output logic [NUM_CH-1:0]                             pulse,
    output logic [NUM_CH-1:0]                             busy
);
    import multi_tick_gen_pkg::*;

    localparam int SEL_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0] chan_we_s;
    logic [31:0]       sel_ext_s;

    // Select values beyond the last channel match nothing and are dropped.
    always_comb begin
        sel_ext_s = {{(32-SEL_W){1'b0}}, cfg_sel};
        chan_we_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (sel_ext_s == 32'(i))) begin
                chan_we_s[i] = 1'b1;
            end else begin
                chan_we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        tick_chan #(
            .CNT_W          (CNT_W),
            .PW_W           (PW_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_PW     (DEFAULT_PW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en[g]),
            .oneshot    (oneshot[g]),
            .start      (start[g]),
            .cfg_we     (chan_we_s[g]),
            .cfg_period (cfg_period),
            .cfg_pw     (cfg_pw),
            .tick       (tick[g]),
            .pulse      (pulse[g]),
            .busy       (busy[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: five channels with a short default
// period so the default-period scenario fits in a short run.
module tb_multi_tick_gen;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 24;
    localparam int PW_W   = 4;
    localparam int DEF_P  = 40;
    localparam int DEF_PW = 10;
    localparam int SEL_W  = 3;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] oneshot;
    logic [NUM_CH-1:0] start;
    logic              cfg_we;
    logic [SEL_W-1:0]  cfg_sel;
    logic [CNT_W-1:0]  cfg_period;
    logic [PW_W-1:0]   cfg_pw;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] busy;

    int pass_cnt;
    int chk_cnt;

    multi_tick_gen #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .PW_W           (PW_W),
        .DEFAULT_PERIOD (DEF_P),
        .DEFAULT_PW     (DEF_PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .oneshot    (oneshot),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_period (cfg_period),
        .cfg_pw     (cfg_pw),
        .tick       (tick),
        .pulse      (pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int p, input int pw);
        cfg_we     = 1'b1;
        cfg_sel    = SEL_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_pw     = PW_W'(pw);
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({tick, pulse, busy} !== 15'd0) begin
            $display("FAIL reset_outputs: tick=%b pulse=%b busy=%b, want all 0", tick, pulse, busy);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_default_period();
        logic exp_t, exp_p;
        en[0] = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            step();
            exp_t = (k == 40) || (k == 80);
            exp_p = (k >= 40 && k < 50) || (k >= 80 && k < 90);
            chk_cnt++;
            if (tick[0] !== exp_t || pulse[0] !== exp_p || busy[0] !== 1'b1) begin
                $display("FAIL default_ch0 k=%0d: tick=%b pulse=%b busy=%b, want %b %b 1",
                         k, tick[0], pulse[0], busy[0], exp_t, exp_p);
            end else begin
                pass_cnt++;
            end
        end
        en[0] = 1'b0;
        step();
    endtask

    task automatic test_cfg_midrun();
        logic exp_t, exp_p;
        cfg_write(1, 5, 2);
        en[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 8) cfg_we = 1'b0;
            exp_t = (k == 5) || (k == 10) || (k == 13) || (k == 16) || (k == 19);
            exp_p = exp_t || (k == 6) || (k == 11) || (k == 14) || (k == 17) || (k == 20);
            chk_cnt++;
            if (tick[1] !== exp_t || pulse[1] !== exp_p || busy[1] !== 1'b1) begin
                $display("FAIL cfg_midrun_ch1 k=%0d: tick=%b pulse=%b busy=%b, want %b %b 1",
                         k, tick[1], pulse[1], busy[1], exp_t, exp_p);
            end else begin
                pass_cnt++;
            end
            if (k == 7) begin
                cfg_we     = 1'b1;
                cfg_sel    = SEL_W'(1);
                cfg_period = CNT_W'(3);
                cfg_pw     = PW_W'(2);
            end
        end
        en[1] = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        logic exp_t, exp_b;
        cfg_write(2, 8, 1);
        oneshot[2] = 1'b1;
        en[2]      = 1'b1;
        step();
        chk_cnt++;
        if (busy[2] !== 1'b0) begin
            $display("FAIL oneshot_wait: busy=%b, want 0", busy[2]);
        end else begin
            pass_cnt++;
        end
        start[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            start[2] = 1'b0;
            exp_t = (k == 8);
            exp_b = (k <= 8);
            chk_cnt++;
            if (tick[2] !== exp_t || busy[2] !== exp_b) begin
                $display("FAIL oneshot_single k=%0d: tick=%b busy=%b, want %b %b",
                         k, tick[2], busy[2], exp_t, exp_b);
            end else begin
                pass_cnt++;
            end
        end
        start[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            start[2] = (k == 4);
            exp_t = (k == 12);
            exp_b = (k <= 12);
            chk_cnt++;
            if (tick[2] !== exp_t || busy[2] !== exp_b) begin
                $display("FAIL oneshot_restart k=%0d: tick=%b busy=%b, want %b %b",
                         k, tick[2], busy[2], exp_t, exp_b);
            end else begin
                pass_cnt++;
            end
        end
        en[2]    = 1'b0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_cnt++;
            if (tick[2] !== 1'b0 || busy[2] !== 1'b0) begin
                $display("FAIL oneshot_start_no_en k=%0d: tick=%b busy=%b, want 0 0",
                         k, tick[2], busy[2]);
            end else begin
                pass_cnt++;
            end
        end
        oneshot[2] = 1'b0;
    endtask

    task automatic test_edge_periods();
        cfg_write(3, 1, 1);
        en[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_cnt++;
            if (tick[3] !== 1'b1) begin
                $display("FAIL p1_every_cycle k=%0d: tick=%b, want 1", k, tick[3]);
            end else begin
                pass_cnt++;
            end
        end
        en[3] = 1'b0;
        step();
        cfg_write(3, 3, 5);
        en[3] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_cnt++;
            if (tick[3] !== (k % 3 == 0) || pulse[3] !== (k >= 3)) begin
                $display("FAIL pw_ge_p k=%0d: tick=%b pulse=%b, want %b %b",
                         k, tick[3], pulse[3], (k % 3 == 0), (k >= 3));
            end else begin
                pass_cnt++;
            end
        end
        en[3] = 1'b0;
        step();
        cfg_write(3, 0, 5);
        en[3] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            chk_cnt++;
            if (tick[3] !== 1'b0 || pulse[3] !== 1'b0 || busy[3] !== 1'b1) begin
                $display("FAIL p0_no_tick k=%0d: tick=%b pulse=%b busy=%b, want 0 0 1",
                         k, tick[3], pulse[3], busy[3]);
            end else begin
                pass_cnt++;
            end
        end
        en[3] = 1'b0;
        step();
    endtask

    task automatic test_en_drop();
        cfg_write(1, 6, 4);
        en[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
        end
        chk_cnt++;
        if (pulse[1] !== 1'b1 || busy[1] !== 1'b1) begin
            $display("FAIL en_drop_pre: pulse=%b busy=%b, want 1 1", pulse[1], busy[1]);
        end else begin
            pass_cnt++;
        end
        en[1] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_cnt++;
            if (tick[1] !== 1'b0 || pulse[1] !== 1'b0 || busy[1] !== 1'b0) begin
                $display("FAIL en_drop_clear k=%0d: tick=%b pulse=%b busy=%b, want 0 0 0",
                         k, tick[1], pulse[1], busy[1]);
            end else begin
                pass_cnt++;
            end
        end
        en[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_cnt++;
            if (tick[1] !== (k == 6)) begin
                $display("FAIL en_reenable k=%0d: tick=%b, want %b", k, tick[1], (k == 6));
            end else begin
                pass_cnt++;
            end
        end
        en[1] = 1'b0;
        step();
    endtask

    task automatic test_reset_midrun();
        cfg_write(0, 7, 3);
        cfg_write(3, 4, 2);
        en = 5'b01011;
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({tick, pulse, busy} !== 15'd0) begin
            $display("FAIL reset_async: tick=%b pulse=%b busy=%b, want all 0", tick, pulse, busy);
        end else begin
            pass_cnt++;
        end
        en = 5'b00000;
        step();
        rst = 1'b0;
        cfg_write(NUM_CH, 3, 1);
        en = 5'b11111;
        for (int k = 1; k <= 41; k++) begin
            step();
            chk_cnt++;
            if (tick !== ((k == 40) ? 5'b11111 : 5'b00000)) begin
                $display("FAIL reset_defaults k=%0d: tick=%b, want %b",
                         k, tick, ((k == 40) ? 5'b11111 : 5'b00000));
            end else begin
                pass_cnt++;
            end
        end
        en = 5'b00000;
        step();
    endtask

    initial begin
        pass_cnt   = 0;
        chk_cnt    = 0;
        rst        = 1'b1;
        en         = 5'b00000;
        oneshot    = 5'b00000;
        start      = 5'b00000;
        cfg_we     = 1'b0;
        cfg_sel    = 3'd0;
        cfg_period = 24'd0;
        cfg_pw     = 4'd0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_default_period();
        test_cfg_midrun();
        test_oneshot();
        test_edge_periods();
        test_en_drop();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
